// File: rtl/lc3_mem_seq.sv
// Memory-access sequencer for the LC3 MAR/DRAM port.
// Runs one LD/ST/LDI/STI at a time through a Moore FSM; read results land in an internal MDR.
module lc3_mem_seq #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             REQ_VALID,
   output logic             REQ_READY,
   input  logic [1:0]       REQ_OP,
   input  logic [WIDTH-1:0] REQ_ADDR,
   input  logic [WIDTH-1:0] REQ_WDATA,
   output logic             RSP_VALID,
   output logic [WIDTH-1:0] RSP_DATA,
   output logic             MAR_LE,
   output logic             MAR_CONTROL,
   output logic             WE,
   output logic [WIDTH-1:0] Y,
   output logic [WIDTH-1:0] RD_DATA,
   input  logic [WIDTH-1:0] DATA
);

   typedef enum logic [2:0] {
      StIdle,
      StSetMar,
      StAccess,
      StPtr,
      StCapture,
      StDone
   } state_t;

   localparam logic [1:0] OpSt  = 2'b01;
   localparam logic [1:0] OpSti = 2'b11;

   state_t           state_q, state_d;
   logic [1:0]       op_q;
   logic [WIDTH-1:0] addr_q;
   logic [WIDTH-1:0] wdata_q;
   logic [WIDTH-1:0] mdr_q;
   logic             ind_q;
   logic             accept;

   assign accept = (state_q == StIdle) && REQ_VALID;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         op_q    <= 2'b00;
         addr_q  <= '0;
         wdata_q <= '0;
         mdr_q   <= '0;
         ind_q   <= 1'b0;
      end else begin
         if (accept) begin
            op_q    <= REQ_OP;
            addr_q  <= REQ_ADDR;
            wdata_q <= REQ_WDATA;
            ind_q   <= REQ_OP[1];
         end
         if (state_q == StPtr) begin
            ind_q <= 1'b0;
         end
         if (state_q == StCapture) begin
            mdr_q <= DATA;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:    if (REQ_VALID) state_d = StSetMar;
         StSetMar:  state_d = StAccess;
         StAccess: begin
            if (ind_q)         state_d = StPtr;
            else if (op_q[0])  state_d = StDone;
            else               state_d = StCapture;
         end
         StPtr:     state_d = StAccess;
         StCapture: state_d = StDone;
         StDone:    state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   always_comb begin
      REQ_READY   = 1'b0;
      MAR_LE      = 1'b0;
      MAR_CONTROL = 1'b0;
      WE          = 1'b0;
      RSP_VALID   = 1'b0;
      unique case (state_q)
         StIdle:   REQ_READY = 1'b1;
         StSetMar: MAR_LE = 1'b1;
         // The pointer-fetch pass of an STI must not write.
         StAccess: WE = (op_q == OpSt) || ((op_q == OpSti) && !ind_q);
         StPtr: begin
            MAR_LE      = 1'b1;
            MAR_CONTROL = 1'b1;
         end
         StDone:   RSP_VALID = 1'b1;
         default: ;
      endcase
   end

   assign Y        = addr_q;
   assign RD_DATA  = wdata_q;
   assign RSP_DATA = mdr_q;

endmodule
